// File: rtl/raizing_video_timer.sv
`default_nettype none
// ============================================================================
//  Module   : raizing_video_timer
//  Purpose  : Parametrised raster timing (position, blanking, sync, strobes).
//             Define RVT_SYNC_ADJ_EN for per-frame runtime sync shifting.
//  Revision : 1.0 - initial release
// ============================================================================
module raizing_video_timer #(
    parameter int HW            = 9,
    parameter int VW            = 9,
    parameter int H_TOTAL       = 432,
    parameter int H_ACTIVE      = 320,
    parameter int HS_START      = 360,
    parameter int HS_END        = 379,
    parameter int V_TOTAL       = 262,
    parameter int V_ACTIVE      = 240,
    parameter int VS_START      = 244,
    parameter int VS_END        = 253,
    parameter int VRENDER_AHEAD = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pxl_cen,
    input  logic [3:0]    h_ofs,
    input  logic [3:0]    v_ofs,
    output logic [HW-1:0] hpos,
    output logic [VW-1:0] vpos,
    output logic [VW-1:0] vrender,
    output logic          lhbl,
    output logic          lvbl,
    output logic          display_on,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_cnt
);

    if (H_TOTAL > (1 << HW) || V_TOTAL > (1 << VW)) begin : g_chk_width
        $fatal(1, "raizing_video_timer: raster does not fit counter width");
    end
    if (HS_END >= H_TOTAL || VS_END >= V_TOTAL) begin : g_chk_sync_end
        $fatal(1, "raizing_video_timer: sync end outside raster");
    end
    if (HS_START < H_ACTIVE || VS_START < V_ACTIVE) begin : g_chk_sync_start
        $fatal(1, "raizing_video_timer: sync start inside active area");
    end
    if (VRENDER_AHEAD >= V_TOTAL) begin : g_chk_ahead
        $fatal(1, "raizing_video_timer: VRENDER_AHEAD too large");
    end

    // Sync windows are evaluated in signed arithmetic two bits wider than the
    // counters so a shifted edge can never wrap before clamping.
    localparam int SWH = HW + 2;
    localparam int SWV = VW + 2;
    localparam int VW1 = VW + 1;

    localparam logic [HW-1:0]         C_H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]         C_V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0]         C_H_ACTIVE = HW'(H_ACTIVE);
    localparam logic [VW-1:0]         C_V_ACTIVE = VW'(V_ACTIVE);
    localparam logic [VW:0]           C_V_TOTAL  = VW1'(V_TOTAL);
    localparam logic [VW:0]           C_AHEAD    = VW1'(VRENDER_AHEAD);
    localparam logic signed [SWH-1:0] C_HS_START = SWH'(HS_START);
    localparam logic signed [SWH-1:0] C_HS_END   = SWH'(HS_END);
    localparam logic signed [SWH-1:0] C_H_MIN    = SWH'(H_ACTIVE);
    localparam logic signed [SWH-1:0] C_H_MAX    = SWH'(H_TOTAL - 1);
    localparam logic signed [SWV-1:0] C_VS_START = SWV'(VS_START);
    localparam logic signed [SWV-1:0] C_VS_END   = SWV'(VS_END);
    localparam logic signed [SWV-1:0] C_V_MIN    = SWV'(V_ACTIVE);
    localparam logic signed [SWV-1:0] C_V_MAX    = SWV'(V_TOTAL - 1);

    logic                  w_h_wrap;
    logic                  w_frame_nxt;
    logic [HW-1:0]         w_h_nxt;
    logic [VW-1:0]         w_v_nxt;
    logic [VW:0]           w_vr_sum;
    logic [VW-1:0]         w_vr_nxt;
    logic signed [3:0]     w_hs_d;
    logic signed [3:0]     w_vs_d;
    logic signed [SWH-1:0] w_h_s, w_hs_lo, w_hs_hi, w_hs_lo_raw, w_hs_hi_raw;
    logic signed [SWV-1:0] w_v_s, w_vs_lo, w_vs_hi, w_vs_lo_raw, w_vs_hi_raw;
    logic                  w_hsync_nxt;
    logic                  w_vsync_nxt;

    always_comb begin
        w_h_wrap    = (hpos == C_H_LAST);
        w_h_nxt     = w_h_wrap ? '0 : hpos + HW'(1);
        w_v_nxt     = vpos;
        if (w_h_wrap) begin
            w_v_nxt = (vpos == C_V_LAST) ? '0 : vpos + VW'(1);
        end
        w_frame_nxt = w_h_wrap && (vpos == C_V_LAST);
        // Wrap by subtraction in VW+1 bits so V_TOTAL-1 plus AHEAD cannot overflow.
        w_vr_sum    = {1'b0, w_v_nxt} + C_AHEAD;
        w_vr_nxt    = (w_vr_sum >= C_V_TOTAL) ? VW'(w_vr_sum - C_V_TOTAL) : VW'(w_vr_sum);
    end

`ifdef RVT_SYNC_ADJ_EN
    logic signed [3:0] r_hs_d;
    logic signed [3:0] r_vs_d;

    // New offsets take effect on the frame_start edge itself so a whole frame
    // always uses one shift.
    assign w_hs_d = w_frame_nxt ? signed'(h_ofs) : r_hs_d;
    assign w_vs_d = w_frame_nxt ? signed'(v_ofs) : r_vs_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hs_d <= '0;
            r_vs_d <= '0;
        end else if (pxl_cen && w_frame_nxt) begin
            r_hs_d <= w_hs_d;
            r_vs_d <= w_vs_d;
        end
    end
`else
    logic w_unused_ofs;

    assign w_hs_d       = '0;
    assign w_vs_d       = '0;
    assign w_unused_ofs = ^{h_ofs, v_ofs};
`endif

    always_comb begin
        w_h_s       = {2'b00, w_h_nxt};
        w_hs_lo_raw = C_HS_START + SWH'(w_hs_d);
        w_hs_hi_raw = C_HS_END + SWH'(w_hs_d);
        w_hs_lo     = (w_hs_lo_raw < C_H_MIN) ? C_H_MIN : w_hs_lo_raw;
        w_hs_hi     = (w_hs_hi_raw > C_H_MAX) ? C_H_MAX : w_hs_hi_raw;
        w_hsync_nxt = (w_h_s >= w_hs_lo) && (w_h_s <= w_hs_hi);

        w_v_s       = {2'b00, w_v_nxt};
        w_vs_lo_raw = C_VS_START + SWV'(w_vs_d);
        w_vs_hi_raw = C_VS_END + SWV'(w_vs_d);
        w_vs_lo     = (w_vs_lo_raw < C_V_MIN) ? C_V_MIN : w_vs_lo_raw;
        w_vs_hi     = (w_vs_hi_raw > C_V_MAX) ? C_V_MAX : w_vs_hi_raw;
        w_vsync_nxt = (w_v_s >= w_vs_lo) && (w_v_s <= w_vs_hi);
    end

    // All outputs are computed from the next position so they change together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos        <= '0;
            vpos        <= '0;
            vrender     <= VW'(VRENDER_AHEAD);
            lhbl        <= 1'b1;
            lvbl        <= 1'b1;
            display_on  <= 1'b1;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pxl_cen) begin
                hpos        <= w_h_nxt;
                vpos        <= w_v_nxt;
                vrender     <= w_vr_nxt;
                lhbl        <= (w_h_nxt < C_H_ACTIVE);
                lvbl        <= (w_v_nxt < C_V_ACTIVE);
                display_on  <= (w_h_nxt < C_H_ACTIVE) && (w_v_nxt < C_V_ACTIVE);
                hsync       <= w_hsync_nxt;
                vsync       <= w_vsync_nxt;
                line_start  <= w_h_wrap;
                frame_start <= w_frame_nxt;
                if (w_frame_nxt) begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_raizing_video_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_raizing_video_timer
//  Purpose  : Randomised bench for two raster geometries against a
//             pulse-count model of the timer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_raizing_video_timer;

    localparam int A_HT = 24, A_HA = 16, A_HSS = 18, A_HSE = 21;
    localparam int A_VT = 12, A_VA = 8,  A_VSS = 9,  A_VSE = 10, A_AH = 1;
    localparam int B_HT = 32, B_HA = 20, B_HSS = 22, B_HSE = 31;
    localparam int B_VT = 16, B_VA = 11, B_VSS = 12, B_VSE = 14, B_AH = 2;

    typedef struct { int ht, ha, hss, hse, vt, va, vss, vse, ah; } geo_t;
    typedef struct { logic [31:0] h, v, vr, lhbl, lvbl, de, hs, vs, ls, fs, fc; } obs_t;

    geo_t ga = '{A_HT, A_HA, A_HSS, A_HSE, A_VT, A_VA, A_VSS, A_VSE, A_AH};
    geo_t gb = '{B_HT, B_HA, B_HSS, B_HSE, B_VT, B_VA, B_VSS, B_VSE, B_AH};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pxl_cen = 1'b0;
    logic [3:0] h_ofs = '0;
    logic [3:0] v_ofs = '0;

    logic [4:0] a_hpos, b_hpos;
    logic [3:0] a_vpos, a_vrender, b_vpos, b_vrender;
    logic       a_lhbl, a_lvbl, a_de, a_hs, a_vs, a_ls, a_fs;
    logic       b_lhbl, b_lvbl, b_de, b_hs, b_vs, b_ls, b_fs;
    logic [7:0] a_fc, b_fc;

    int n_chk = 0;
    int n_pass = 0;
    int n_adv = 0;
    bit adv = 1'b0;
    int hd_a = 0, vd_a = 0, hd_b = 0, vd_b = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    raizing_video_timer #(
        .HW(5), .VW(4), .H_TOTAL(A_HT), .H_ACTIVE(A_HA), .HS_START(A_HSS), .HS_END(A_HSE),
        .V_TOTAL(A_VT), .V_ACTIVE(A_VA), .VS_START(A_VSS), .VS_END(A_VSE), .VRENDER_AHEAD(A_AH)
    ) u_a (
        .clk(clk), .reset(reset), .pxl_cen(pxl_cen), .h_ofs(h_ofs), .v_ofs(v_ofs),
        .hpos(a_hpos), .vpos(a_vpos), .vrender(a_vrender), .lhbl(a_lhbl), .lvbl(a_lvbl),
        .display_on(a_de), .hsync(a_hs), .vsync(a_vs), .line_start(a_ls),
        .frame_start(a_fs), .frame_cnt(a_fc)
    );

    raizing_video_timer #(
        .HW(5), .VW(4), .H_TOTAL(B_HT), .H_ACTIVE(B_HA), .HS_START(B_HSS), .HS_END(B_HSE),
        .V_TOTAL(B_VT), .V_ACTIVE(B_VA), .VS_START(B_VSS), .VS_END(B_VSE), .VRENDER_AHEAD(B_AH)
    ) u_b (
        .clk(clk), .reset(reset), .pxl_cen(pxl_cen), .h_ofs(h_ofs), .v_ofs(v_ofs),
        .hpos(b_hpos), .vpos(b_vpos), .vrender(b_vrender), .lhbl(b_lhbl), .lvbl(b_lvbl),
        .display_on(b_de), .hsync(b_hs), .vsync(b_vs), .line_start(b_ls),
        .frame_start(b_fs), .frame_cnt(b_fc)
    );

    function automatic int imax(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    function automatic int imin(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

    // Everything follows from the number of pixel pulses since reset.
    function automatic obs_t model(input int n, input bit a, input int hd, input int vd,
                                   input geo_t g);
        obs_t e;
        int h, v;
        h = n % g.ht;
        v = (n / g.ht) % g.vt;
        e.h    = h;
        e.v    = v;
        e.vr   = (v + g.ah) % g.vt;
        e.lhbl = 32'(h < g.ha);
        e.lvbl = 32'(v < g.va);
        e.de   = 32'((h < g.ha) && (v < g.va));
        e.hs   = 32'((h >= imax(g.hss + hd, g.ha)) && (h <= imin(g.hse + hd, g.ht - 1)));
        e.vs   = 32'((v >= imax(g.vss + vd, g.va)) && (v <= imin(g.vse + vd, g.vt - 1)));
        e.ls   = 32'(a && (h == 0));
        e.fs   = 32'(a && (h == 0) && (v == 0));
        e.fc   = (n / (g.ht * g.vt)) % 256;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_obs(input string tag, input obs_t act, input obs_t exp);
        chk({tag, ".hpos"},        act.h,    exp.h);
        chk({tag, ".vpos"},        act.v,    exp.v);
        chk({tag, ".vrender"},     act.vr,   exp.vr);
        chk({tag, ".lhbl"},        act.lhbl, exp.lhbl);
        chk({tag, ".lvbl"},        act.lvbl, exp.lvbl);
        chk({tag, ".display_on"},  act.de,   exp.de);
        chk({tag, ".hsync"},       act.hs,   exp.hs);
        chk({tag, ".vsync"},       act.vs,   exp.vs);
        chk({tag, ".line_start"},  act.ls,   exp.ls);
        chk({tag, ".frame_start"}, act.fs,   exp.fs);
        chk({tag, ".frame_cnt"},   act.fc,   exp.fc);
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            n_adv <= 0;
            adv   <= 1'b0;
            hd_a  <= 0;
            vd_a  <= 0;
            hd_b  <= 0;
            vd_b  <= 0;
        end else begin
            adv <= pxl_cen;
            if (pxl_cen) begin
                n_adv <= n_adv + 1;
`ifdef RVT_SYNC_ADJ_EN
                if ((n_adv + 1) % (A_HT * A_VT) == 0) begin
                    hd_a <= int'($signed(h_ofs));
                    vd_a <= int'($signed(v_ofs));
                end
                if ((n_adv + 1) % (B_HT * B_VT) == 0) begin
                    hd_b <= int'($signed(h_ofs));
                    vd_b <= int'($signed(v_ofs));
                end
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk_obs("A", '{32'(a_hpos), 32'(a_vpos), 32'(a_vrender), 32'(a_lhbl), 32'(a_lvbl),
                           32'(a_de), 32'(a_hs), 32'(a_vs), 32'(a_ls), 32'(a_fs), 32'(a_fc)},
                    model(n_adv, adv, hd_a, vd_a, ga));
            chk_obs("B", '{32'(b_hpos), 32'(b_vpos), 32'(b_vrender), 32'(b_lhbl), 32'(b_lvbl),
                           32'(b_de), 32'(b_hs), 32'(b_vs), 32'(b_ls), 32'(b_fs), 32'(b_fc)},
                    model(n_adv, adv, hd_b, vd_b, gb));
        end
    end

    task automatic tick(input bit cen);
        @(posedge clk);
        #2;
        pxl_cen = cen;
    endtask

    task automatic random_run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if (i % 150 == 0) begin
                h_ofs = 4'($urandom);
                v_ofs = 4'($urandom);
            end
            tick(bit'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        int guard;
        repeat (3) @(posedge clk);
        #2;
        cmp_en = 1'b1;
        chk("reset.a_hpos", 32'(a_hpos), 0);
        chk("reset.a_vrender", 32'(a_vrender), 1);
        chk("reset.b_vrender", 32'(b_vrender), 2);
        chk("reset.a_lhbl", 32'(a_lhbl), 1);
        chk("reset.a_hsync", 32'(a_hs), 0);
        chk("reset.a_frame_cnt", 32'(a_fc), 0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Every 4th clock, two frames of geometry A.
        repeat (2 * A_HT * A_VT) begin
            tick(1'b1); tick(1'b0); tick(1'b0); tick(1'b0);
        end
        chk("twoframes.a_frame_cnt", 32'(a_fc), 2);
        chk("twoframes.b_frame_cnt", 32'(b_fc), 1);
        chk("twoframes.a_hpos", 32'(a_hpos), 0);
        chk("twoframes.a_vpos", 32'(a_vpos), 0);

        // Last pixel of the frame, then the wrap.
        repeat (A_HT * A_VT - 1) tick(1'b1);
        tick(1'b0);
        chk("corner.a_hpos", 32'(a_hpos), 23);
        chk("corner.a_vpos", 32'(a_vpos), 11);
        chk("corner.a_vrender", 32'(a_vrender), 0);
        tick(1'b1);
        tick(1'b0);
        chk("wrap.a_hpos", 32'(a_hpos), 0);
        chk("wrap.a_vpos", 32'(a_vpos), 0);
        chk("wrap.a_line_start", 32'(a_ls), 1);
        chk("wrap.a_frame_start", 32'(a_fs), 1);
        chk("wrap.a_frame_cnt", 32'(a_fc), 3);

        // Geometry B vrender wrap with AHEAD=2.
        repeat (96) tick(1'b1);
        tick(1'b0);
        chk("bwrap.b_vpos14", 32'(b_vpos), 14);
        chk("bwrap.b_vrender14", 32'(b_vrender), 0);
        repeat (32) tick(1'b1);
        tick(1'b0);
        chk("bwrap.b_vpos15", 32'(b_vpos), 15);
        chk("bwrap.b_vrender15", 32'(b_vrender), 1);

        random_run(3000);
        repeat (100) tick(1'b0);
        random_run(1000);

        // Reset mid-frame at A position (20,5).
        tick(1'b0);
        guard = 0;
        while ((n_adv % (A_HT * A_VT)) != 140 && guard < 400) begin
            tick(1'b1);
            tick(1'b0);
            guard++;
        end
        if (guard >= 400) begin
            n_chk++;
            $display("FAIL reset.align: position not reached within 400 pulses");
        end
        chk("prereset.a_hpos", 32'(a_hpos), 20);
        chk("prereset.a_vpos", 32'(a_vpos), 5);
        #1;
        reset   = 1'b1;
        pxl_cen = 1'b1;
        #1;
        chk("inreset.a_hpos", 32'(a_hpos), 0);
        chk("inreset.a_vpos", 32'(a_vpos), 0);
        chk("inreset.a_vrender", 32'(a_vrender), 1);
        chk("inreset.a_lhbl", 32'(a_lhbl), 1);
        chk("inreset.a_frame_cnt", 32'(a_fc), 0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        tick(1'b0);
        chk("postreset.a_hpos", 32'(a_hpos), 1);
        chk("postreset.a_vpos", 32'(a_vpos), 0);
        chk("postreset.a_frame_cnt", 32'(a_fc), 0);
        chk("postreset.a_frame_start", 32'(a_fs), 0);

        random_run(1500);
        tick(1'b0);
        tick(1'b0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/raizing_video_timer.md
# raizing_video_timer

Parametrised video timing generator for the Raizing cores. Free-running horizontal and vertical counters advance on the pixel clock enable and drive the beam position, blanking, sync, render-line lookahead, and line/frame strobes. It sits between the system clock domain and the tilemap, sprite and colour-mixer blocks. Every raster geometry is set by parameter. An optional runtime sync-position adjust is available.

## Interface
Parameters:
- HW, 9: hpos width
- VW, 9: vpos/vrender width
- H_TOTAL, 432: pixels per line, including blanking
- H_ACTIVE, 320: visible pixels per line
- HS_START, 360: first hsync pixel
- HS_END, 379: last hsync pixel, inclusive
- V_TOTAL, 262: lines per frame
- V_ACTIVE, 240: visible lines
- VS_START, 244: first vsync line
- VS_END, 253: last vsync line, inclusive
- VRENDER_AHEAD, 1: lines by which vrender leads vpos

Ports (one clock; `reset` is asynchronous, active-high):
- clk, in, 1: system clock
- reset, in, 1: asynchronous reset, active-high
- pxl_cen, in, 1: pixel clock enable
- h_ofs, in, 4: signed hsync shift in pixels (used only with RVT_SYNC_ADJ_EN)
- v_ofs, in, 4: signed vsync shift in lines (used only with RVT_SYNC_ADJ_EN)
- hpos, out, HW: current pixel
- vpos, out, VW: current line
- vrender, out, VW: line currently being rendered ahead of the beam
- lhbl, out, 1: 1 = horizontal active (not blanked)
- lvbl, out, 1: 1 = vertical active
- display_on, out, 1: lhbl & lvbl
- hsync, out, 1: active-high
- vsync, out, 1: active-high
- line_start, out, 1: one-clk pulse, hpos became 0
- frame_start, out, 1: one-clk pulse, (hpos,vpos) became (0,0)
- frame_cnt, out, 8: frames completed, mod 256

## Operation
- The counters advance only on clk edges with pxl_cen=1. With pxl_cen=0, every output holds, and line_start/frame_start are 0.
- hpos counts 0..H_TOTAL-1 and then wraps to 0. vpos increments on each hpos wrap and itself wraps V_TOTAL-1 -> 0.
- lhbl = (hpos < H_ACTIVE). lvbl = (vpos < V_ACTIVE).
- hsync = (HS_START+hs_d <= hpos <= HS_END+hs_d). vsync = (VS_START+vs_d <= vpos <= VS_END+vs_d).
  - hs_d and vs_d are the active offsets. They are 0 unless the macro is enabled.
- vrender = (vpos + VRENDER_AHEAD) mod V_TOTAL. The wrap is computed without overflow: V_TOTAL-1 with AHEAD=1 gives 0.
- frame_cnt increments on each frame_start, 255 -> 0.
- The parameters are checked at elaboration. Any of the following is a fatal error:
  - H_TOTAL > 2^HW or V_TOTAL > 2^VW
  - HS_END >= H_TOTAL or VS_END >= V_TOTAL
  - HS_START < H_ACTIVE or VS_START < V_ACTIVE
  - VRENDER_AHEAD >= V_TOTAL
- Reset mid-frame: all state is cleared immediately. Counting restarts at (0,0) on the first pxl_cen after reset is released. No frame_start pulse is issued for the reset itself.

## Timing
- Every output is registered and changes on the same clk edge as hpos/vpos, so there is zero skew between position and the derived signals.
- line_start and frame_start are high for exactly the one clk cycle that follows the advancing edge.
- Reset values:
  - hpos = 0, vpos = 0, vrender = VRENDER_AHEAD
  - lhbl = 1, lvbl = 1, display_on = 1
  - hsync = 0, vsync = 0
  - line_start = 0, frame_start = 0, frame_cnt = 0
  - hs_d = 0, vs_d = 0
- Frame period = H_TOTAL*V_TOTAL pxl_cen pulses.

## Configuration
- RVT_SYNC_ADJ_EN defined:
  - h_ofs and v_ofs are sign-extended and sampled into hs_d/vs_d on the advancing edge that produces frame_start. The shift therefore never changes mid-frame.
  - The shifted windows are clamped so they stay inside blanking:
    - HS_START+hs_d is clamped to >= H_ACTIVE.
    - HS_END+hs_d is clamped to <= H_TOTAL-1.
    - The vertical window is clamped the same way.
- RVT_SYNC_ADJ_EN undefined: h_ofs and v_ofs are ignored, hs_d = vs_d = 0, and no offset registers are built.

## Test plan
- Defaults, pxl_cen every 4th clk, run 2 frames:
  - hsync is high for hpos 360..379 (20 pixels).
  - lhbl falls at hpos 320.
  - vsync is high for lines 244..253.
  - frame_start fires every 432*262 = 113184 pxl_cen pulses.
  - frame_cnt reads 2.
- Wrap corner (defaults): at (431,261), one pxl_cen gives (0,0) with line_start = frame_start = 1. At vpos = 261, vrender = 0.
- pxl_cen held low for 100 clk mid-line: all outputs are frozen and no strobes fire. Counting resumes from the same hpos.
- Assert reset at (200,100), release 3 clk later:
  - Outputs go to their reset values within the reset cycle.
  - The first pxl_cen after release gives hpos = 1, vpos = 0.
  - frame_cnt stays at 0 until the next full frame.
- RVT_SYNC_ADJ_EN:
  - h_ofs = -3 applied mid-frame: hsync stays at 360..379 until the next frame_start, then moves to 357..376.
  - h_ofs = +7 with HS_END = 429: hsync end is clamped at 431.
- Non-default parameters (H_TOTAL 384, H_ACTIVE 256, V_TOTAL 264, V_ACTIVE 224, VRENDER_AHEAD 2): lhbl falls at 256, and vrender = 0 at vpos = 262.
